zp_cache_dma_arbiter: RTL and testbench

- Shares one DRAM-side bsg_cache DMA port (pkt / read-data / write-data) between two DMA requesters, e.g. the unicore L2 and a host-side preload/flush engine.
- Round-robin packet arbitration with grant hold.
- An in-order routing FIFO steers returning read bursts to their requester.
- A single write-burst lock steers write-data beats from the requester that issued the write packet.

---
 rtl/zp_dma_arb_pkg.sv | 13 +
 rtl/zp_dma_route_fifo.sv | 68 ++++++
 rtl/zp_cache_dma_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_zp_cache_dma_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zp_dma_arb_pkg.sv
// rtl/zp_dma_arb_pkg.sv - shared types and packet-field helpers for the DRAM DMA port arbiter
package zp_dma_arb_pkg;

    typedef logic req_id_t;

    typedef enum logic {e_w_idle, e_w_busy} wr_state_e;

    // The write_not_read flag sits directly above the address field.
    function automatic int unsigned pkt_wnr_idx(input int unsigned caddr_width);
        return caddr_width;
    endfunction

endpackage

// File: rtl/zp_dma_route_fifo.sv
// rtl/zp_dma_route_fifo.sv - in-order requester-id FIFO for outstanding read bursts, pops on the last beat
module zp_dma_route_fifo
    import zp_dma_arb_pkg::*;
#(
    parameter int unsigned els_p       = 4,
    parameter int unsigned burst_len_p = 8
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    beat_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int unsigned ptr_w_lp = $clog2(els_p);
    localparam int unsigned cnt_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(burst_len_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp   = cnt_w_lp'(1);
    localparam logic [ptr_w_lp:0]   ptr_one_lp   = (ptr_w_lp + 1)'(1);

    req_id_t [els_p-1:0]  mem_q, mem_d;
    logic [ptr_w_lp:0]    wptr_q, wptr_d;
    logic [ptr_w_lp:0]    rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]  rd_cnt_q, rd_cnt_d;
    logic                 pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                  && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
    assign head_o  = mem_q[rptr_q[ptr_w_lp-1:0]];
    assign pop     = beat_i && !empty_o && (rd_cnt_q == last_beat_lp);

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rd_cnt_d = rd_cnt_q;
        if (push_i) begin
            mem_d[wptr_q[ptr_w_lp-1:0]] = push_id_i;
            wptr_d = wptr_q + ptr_one_lp;
        end
        if (beat_i && !empty_o) begin
            rd_cnt_d = pop ? '0 : rd_cnt_q + cnt_one_lp;
        end
        if (pop) begin
            rptr_d = rptr_q + ptr_one_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            rd_cnt_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: rtl/zp_cache_dma_arbiter.sv
// rtl/zp_cache_dma_arbiter.sv - two-requester arbiter for one bsg_cache DRAM DMA port; ZP_DMA_ARB_PERF_EN adds grant counters
module zp_cache_dma_arbiter
    import zp_dma_arb_pkg::*;
#(
    parameter int unsigned caddr_width_p   = 28,
    parameter int unsigned l2_fill_width_p = 64,
    parameter int unsigned burst_len_p     = 8,
    parameter int unsigned route_els_p     = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [1:0][caddr_width_p:0]         req_pkt_i,
    input  logic [1:0]                          req_pkt_v_i,
    output logic [1:0]                          req_pkt_yumi_o,
    output logic [l2_fill_width_p-1:0]          req_data_o,
    output logic [1:0]                          req_data_v_o,
    input  logic [1:0]                          req_data_ready_and_i,
    input  logic [1:0][l2_fill_width_p-1:0]     req_data_i,
    input  logic [1:0]                          req_data_v_i,
    output logic [1:0]                          req_data_yumi_o,
    output logic [caddr_width_p:0]              dma_pkt_o,
    output logic                                dma_pkt_v_o,
    input  logic                                dma_pkt_yumi_i,
    input  logic [l2_fill_width_p-1:0]          dma_data_i,
    input  logic                                dma_data_v_i,
    output logic                                dma_data_ready_and_o,
    output logic [l2_fill_width_p-1:0]          dma_data_o,
    output logic                                dma_data_v_o,
    input  logic                                dma_data_yumi_i,
    output logic [1:0][31:0]                    pkt_count_o
);

    localparam int unsigned wnr_bit_lp = pkt_wnr_idx(caddr_width_p);
    localparam int unsigned wcnt_w_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam logic [wcnt_w_lp-1:0] wr_last_lp = wcnt_w_lp'(burst_len_p - 1);
    localparam logic [wcnt_w_lp-1:0] wr_one_lp  = wcnt_w_lp'(1);

    logic [1:0]           pkt_is_wr;
    logic [1:0]           elig;
    req_id_t              winner;
    logic                 pkt_fire;
    logic                 route_push;
    logic                 rd_beat;
    logic                 fifo_full;
    logic                 fifo_empty;
    req_id_t              fifo_head;

    req_id_t              rr_last_q, rr_last_d;
    logic                 hold_q, hold_d;
    req_id_t              hold_id_q, hold_id_d;
    wr_state_e            wr_state_q, wr_state_d;
    req_id_t              wr_owner_q, wr_owner_d;
    logic [wcnt_w_lp-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        pkt_is_wr = '0;
        elig      = '0;
        for (int i = 0; i < 2; i++) begin
            pkt_is_wr[i] = req_pkt_i[i][wnr_bit_lp];
            elig[i]      = req_pkt_v_i[i]
                        && (pkt_is_wr[i] ? (wr_state_q == e_w_idle) : !fifo_full);
        end
    end

    // A stalled grant stays with its winner so the presented packet cannot change.
    always_comb begin
        winner = 1'b0;
        if (hold_q) begin
            winner = hold_id_q;
        end else if (&elig) begin
            winner = ~rr_last_q;
        end else begin
            winner = elig[1];
        end
    end

    assign dma_pkt_v_o    = hold_q | (|elig);
    assign dma_pkt_o      = req_pkt_i[winner];
    assign pkt_fire       = dma_pkt_v_o & dma_pkt_yumi_i;
    assign req_pkt_yumi_o = {pkt_fire & winner, pkt_fire & ~winner};
    assign route_push     = pkt_fire & ~pkt_is_wr[winner];

    always_comb begin
        rr_last_d       = rr_last_q;
        hold_d          = hold_q;
        hold_id_d       = hold_id_q;
        wr_state_d      = wr_state_q;
        wr_owner_d      = wr_owner_q;
        wr_cnt_d        = wr_cnt_q;
        dma_data_v_o    = 1'b0;
        req_data_yumi_o = '0;

        if (dma_pkt_v_o && !dma_pkt_yumi_i) begin
            hold_d    = 1'b1;
            hold_id_d = winner;
        end else if (pkt_fire) begin
            hold_d    = 1'b0;
            rr_last_d = winner;
        end

        case (wr_state_q)
            e_w_idle: begin
                if (pkt_fire && pkt_is_wr[winner]) begin
                    wr_state_d = e_w_busy;
                    wr_owner_d = winner;
                    wr_cnt_d   = '0;
                end
            end
            e_w_busy: begin
                dma_data_v_o                = req_data_v_i[wr_owner_q];
                req_data_yumi_o[wr_owner_q] = dma_data_yumi_i;
                if (dma_data_yumi_i) begin
                    if (wr_cnt_q == wr_last_lp) begin
                        wr_state_d = e_w_idle;
                        wr_cnt_d   = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + wr_one_lp;
                    end
                end
            end
            default: wr_state_d = e_w_idle;
        endcase
    end

    assign dma_data_o = req_data_i[wr_owner_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_last_q  <= 1'b1;
            hold_q     <= 1'b0;
            hold_id_q  <= 1'b0;
            wr_state_q <= e_w_idle;
            wr_owner_q <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            hold_q     <= hold_d;
            hold_id_q  <= hold_id_d;
            wr_state_q <= wr_state_d;
            wr_owner_q <= wr_owner_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    zp_dma_route_fifo #(
        .els_p       (route_els_p),
        .burst_len_p (burst_len_p)
    ) route_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (route_push),
        .push_id_i (winner),
        .beat_i    (rd_beat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

    assign req_data_o           = dma_data_i;
    assign req_data_v_o         = {dma_data_v_i & ~fifo_empty & fifo_head,
                                   dma_data_v_i & ~fifo_empty & ~fifo_head};
    assign dma_data_ready_and_o = ~fifo_empty & req_data_ready_and_i[fifo_head];
    assign rd_beat              = dma_data_v_i & dma_data_ready_and_o;

    a_no_orphan_read_data: assert property (@(posedge clk_i) disable iff (reset_i)
        !(dma_data_v_i && fifo_empty));

`ifdef ZP_DMA_ARB_PERF_EN
    logic [1:0][31:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        for (int i = 0; i < 2; i++) begin
            if (req_pkt_yumi_o[i]) begin
                pkt_count_d[i] = pkt_count_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
`else
    assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_zp_cache_dma_arbiter.sv
// tb/tb_zp_cache_dma_arbiter.sv - directed self-checking bench for zp_cache_dma_arbiter
module tb_zp_cache_dma_arbiter;

    logic              clk_i;
    logic              reset_i;
    logic [1:0][28:0]  req_pkt_i;
    logic [1:0]        req_pkt_v_i;
    logic [1:0]        req_pkt_yumi_o;
    logic [63:0]       req_data_o;
    logic [1:0]        req_data_v_o;
    logic [1:0]        req_data_ready_and_i;
    logic [1:0][63:0]  req_data_i;
    logic [1:0]        req_data_v_i;
    logic [1:0]        req_data_yumi_o;
    logic [28:0]       dma_pkt_o;
    logic              dma_pkt_v_o;
    logic              dma_pkt_yumi_i;
    logic [63:0]       dma_data_i;
    logic              dma_data_v_i;
    logic              dma_data_ready_and_o;
    logic [63:0]       dma_data_o;
    logic              dma_data_v_o;
    logic              dma_data_yumi_i;
    logic [1:0][31:0]  pkt_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    zp_cache_dma_arbiter dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .req_pkt_i            (req_pkt_i),
        .req_pkt_v_i          (req_pkt_v_i),
        .req_pkt_yumi_o       (req_pkt_yumi_o),
        .req_data_o           (req_data_o),
        .req_data_v_o         (req_data_v_o),
        .req_data_ready_and_i (req_data_ready_and_i),
        .req_data_i           (req_data_i),
        .req_data_v_i         (req_data_v_i),
        .req_data_yumi_o      (req_data_yumi_o),
        .dma_pkt_o            (dma_pkt_o),
        .dma_pkt_v_o          (dma_pkt_v_o),
        .dma_pkt_yumi_i       (dma_pkt_yumi_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_ready_and_o (dma_data_ready_and_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_yumi_i      (dma_data_yumi_i),
        .pkt_count_o          (pkt_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [28:0] p_rd0 = 29'h000_1000;
    localparam logic [28:0] p_rd1 = 29'h000_2000;
    localparam logic [28:0] p_rd5 = 29'h000_5000;
    localparam logic [28:0] p_hd0 = 29'h000_7000;
    localparam logic [28:0] p_hd1 = 29'h000_8000;
    localparam logic [28:0] p_wr0 = {1'b1, 28'h000_0100};
    localparam logic [28:0] p_wr1 = {1'b1, 28'h000_0200};

    logic [63:0] perf_exp;
    logic [1:0]  v_exp;
    logic [63:0] dat;
    int          head_exp [5] = '{0, 1, 0, 1, 0};

    initial begin
        reset_i              = 1'b1;
        req_pkt_i            = '0;
        req_pkt_v_i          = '0;
        req_data_ready_and_i = 2'b11;
        req_data_i           = '0;
        req_data_v_i         = '0;
        dma_pkt_yumi_i       = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b0;
        dma_data_yumi_i      = 1'b0;
        tick();
        tick();
        chk("rst_pkt_v",    64'(dma_pkt_v_o), 64'd0);
        chk("rst_pkt_yumi", 64'(req_pkt_yumi_o), 64'd0);
        chk("rst_rd_v",     64'(req_data_v_o), 64'd0);
        chk("rst_rd_ready", 64'(dma_data_ready_and_o), 64'd0);
        chk("rst_wr_v",     64'(dma_data_v_o), 64'd0);
        chk("rst_wr_yumi",  64'(req_data_yumi_o), 64'd0);
        chk("rst_perf",     64'(pkt_count_o), 64'd0);

        // Both requesters issue reads back to back: grants alternate starting at 0.
        reset_i        = 1'b0;
        req_pkt_i[0]   = p_rd0;
        req_pkt_i[1]   = p_rd1;
        req_pkt_v_i    = 2'b11;
        dma_pkt_yumi_i = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_pkt_v",    64'(dma_pkt_v_o), 64'd1);
            chk("rr_yumi",     64'(req_pkt_yumi_o), (g % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_pkt",      64'(dma_pkt_o), (g % 2 == 0) ? 64'(p_rd0) : 64'(p_rd1));
            tick();
        end

        // Route FIFO is full; a fifth read waits for the first burst's last beat.
        req_pkt_v_i  = 2'b01;
        req_pkt_i[0] = p_rd5;
        dma_data_v_i = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) begin
                dat        = 64'hD000_0000_0000_0000 | 64'(b * 256 + k);
                dma_data_i = dat;
                v_exp      = (head_exp[b] == 0) ? 2'b01 : 2'b10;
                if (b == 1 && k == 3) begin
                    req_data_ready_and_i = 2'b01;
                    for (int s = 0; s < 3; s++) begin
                        #1;
                        chk("bp_ready", 64'(dma_data_ready_and_o), 64'd0);
                        chk("bp_rd_v",  64'(req_data_v_o), 64'd2);
                        tick();
                    end
                    req_data_ready_and_i = 2'b11;
                end
                #1;
                chk("rd_v",     64'(req_data_v_o), 64'(v_exp));
                chk("rd_data",  req_data_o, dat);
                chk("rd_ready", 64'(dma_data_ready_and_o), 64'd1);
                if (b == 0) begin
                    chk("full_no_grant", 64'(dma_pkt_v_o), 64'd0);
                end
                if (b == 1 && k == 0) begin
                    chk("after_pop_v",    64'(dma_pkt_v_o), 64'd1);
                    chk("after_pop_yumi", 64'(req_pkt_yumi_o), 64'd1);
                    chk("after_pop_pkt",  64'(dma_pkt_o), 64'(p_rd5));
                end
                tick();
                if (b == 1 && k == 0) begin
                    req_pkt_v_i = 2'b00;
                end
            end
        end
        dma_data_v_i = 1'b0;
        #1;
        chk("drained_ready", 64'(dma_data_ready_and_o), 64'd0);
        chk("drained_rd_v",  64'(req_data_v_o), 64'd0);
`ifdef ZP_DMA_ARB_PERF_EN
        perf_exp = {32'd2, 32'd3};
`else
        perf_exp = 64'd0;
`endif
        chk("perf_after_reads", 64'(pkt_count_o), perf_exp);

        // Grant hold: DRAM stalls 5 cycles while requester 1 (the rr favourite) appears.
        tick();
        req_pkt_i[0]   = p_hd0;
        req_pkt_i[1]   = p_hd1;
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b0;
        #1;
        chk("hold_v0",    64'(dma_pkt_v_o), 64'd1);
        chk("hold_pkt0",  64'(dma_pkt_o), 64'(p_hd0));
        chk("hold_yumi0", 64'(req_pkt_yumi_o), 64'd0);
        tick();
        req_pkt_v_i = 2'b11;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("hold_pkt",  64'(dma_pkt_o), 64'(p_hd0));
            chk("hold_yumi", 64'(req_pkt_yumi_o), 64'd0);
            tick();
        end
        dma_pkt_yumi_i = 1'b1;
        #1;
        chk("hold_release_yumi", 64'(req_pkt_yumi_o), 64'd1);
        chk("hold_release_pkt",  64'(dma_pkt_o), 64'(p_hd0));
        tick();
        req_pkt_v_i = 2'b10;
        #1;
        chk("hold_next_yumi", 64'(req_pkt_yumi_o), 64'd2);
        chk("hold_next_pkt",  64'(dma_pkt_o), 64'(p_hd1));
        tick();
        req_pkt_v_i    = 2'b00;
        dma_pkt_yumi_i = 1'b0;
        #1;
`ifdef ZP_DMA_ARB_PERF_EN
        perf_exp = {32'd3, 32'd4};
`else
        perf_exp = 64'd0;
`endif
        chk("perf_after_hold", 64'(pkt_count_o), perf_exp);

        // Reset with two read bursts still outstanding.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("midrst_perf",  64'(pkt_count_o), 64'd0);
        chk("midrst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
        chk("midrst_ready", 64'(dma_data_ready_and_o), 64'd0);

        // Write from requester 0, competing write from requester 1 one cycle later.
        req_pkt_i[0]   = p_wr0;
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b1;
        #1;
        chk("wr0_yumi", 64'(req_pkt_yumi_o), 64'd1);
        chk("wr0_pkt",  64'(dma_pkt_o), 64'(p_wr0));
        tick();
        req_pkt_i[1]    = p_wr1;
        req_pkt_v_i     = 2'b10;
        req_data_v_i    = 2'b11;
        req_data_i[1]   = 64'hBAD1_BAD1_BAD1_BAD1;
        dma_data_yumi_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_data_i[0] = 64'hA000_0000_0000_0000 | 64'(k);
            if (k == 2) begin
                dma_data_yumi_i = 1'b0;
                #1;
                chk("wr0_stall_yumi", 64'(req_data_yumi_o), 64'd0);
                chk("wr0_stall_v",    64'(dma_data_v_o), 64'd1);
                tick();
                dma_data_yumi_i = 1'b1;
            end
            #1;
            chk("wr0_data",     dma_data_o, 64'hA000_0000_0000_0000 | 64'(k));
            chk("wr0_dyumi",    64'(req_data_yumi_o), 64'd1);
            chk("wr1_blocked",  64'(dma_pkt_v_o), 64'd0);
            tick();
        end
        #1;
        chk("wr1_pkt_v",     64'(dma_pkt_v_o), 64'd1);
        chk("wr1_yumi",      64'(req_pkt_yumi_o), 64'd2);
        chk("wr1_pkt",       64'(dma_pkt_o), 64'(p_wr1));
        chk("idle_wr_v",     64'(dma_data_v_o), 64'd0);
        chk("idle_wr_yumi",  64'(req_data_yumi_o), 64'd0);
        tick();
        req_pkt_v_i   = 2'b00;
        req_data_i[0] = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 8; k++) begin
            req_data_i[1] = 64'hB000_0000_0000_0000 | 64'(k);
            #1;
            chk("wr1_data",  dma_data_o, 64'hB000_0000_0000_0000 | 64'(k));
            chk("wr1_dyumi", 64'(req_data_yumi_o), 64'd2);
            tick();
        end
        #1;
        chk("end_wr_v",    64'(dma_data_v_o), 64'd0);
        chk("end_wr_yumi", 64'(req_data_yumi_o), 64'd0);
`ifdef ZP_DMA_ARB_PERF_EN
        perf_exp = {32'd1, 32'd1};
`else
        perf_exp = 64'd0;
`endif
        chk("perf_after_writes", 64'(pkt_count_o), perf_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
